imem_boot_loader: RTL and testbench

//  Byte-stream program loader that sits upstream of riscv_Rtype_top.

---
 rtl/imem_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: receives a 16-bit little-endian word count followed
// by the image bytes, packs them LSB-first into 32-bit words, writes them into
// the instruction memory and releases the core reset once the image is in.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the core is released.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    // Status flag sets, ordered {s_ready, busy, done, err, core_rst_n}
    localparam logic [4:0] F_RUN   = 5'b11000;
    localparam logic [4:0] F_FLUSH = 5'b01000;
    localparam logic [4:0] F_DONE  = 5'b00101;
    localparam logic [4:0] F_ERR   = 5'b00010;

    // FLUSH is the cycle the final imem write is presented; no byte is taken there
    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        FLUSH,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [15:0] len_q;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        accept;
    logic [15:0] len_hdr;
    logic        last_word;

    // Handshake, full header as seen on the LEN_HI byte, and last-word detect
    assign accept    = s_valid & s_ready;
    assign len_hdr   = {s_data, len_q[7:0]};
    assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, len_q};

    // Loader FSM with registered status, write port and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                                   <= LEN_LO;
            {s_ready, busy, done, err, core_rst_n}  <= F_RUN;
            imem_we                                 <= 1'b0;
            imem_addr                               <= '0;
            imem_wdata                              <= '0;
            len_q                                   <= '0;
            byte_idx                                <= '0;
            asm_q                                   <= '0;
            words_loaded                            <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q                                   <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= s_data;
                        state      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_q <= len_hdr;
                        if (len_hdr == 16'd0) begin
                            state                                  <= FLUSH;
                            {s_ready, busy, done, err, core_rst_n} <= F_FLUSH;
                        end else if ({1'b0, len_hdr} > CAPACITY) begin
                            state                                  <= ERROR;
                            {s_ready, busy, done, err, core_rst_n} <= F_ERR;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ s_data;
`endif
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                            imem_wdata   <= {s_data, asm_q};
                            words_loaded <= words_loaded + CNT_W'(1);
                            if (last_word) begin
                                state                                  <= FLUSH;
                                {s_ready, busy, done, err, core_rst_n} <= F_FLUSH;
                            end
                        end else begin
                            case (byte_idx)
                                2'd0:    asm_q[7:0]   <= s_data;
                                2'd1:    asm_q[15:8]  <= s_data;
                                default: asm_q[23:16] <= s_data;
                            endcase
                        end
                    end
                end
                FLUSH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state                                  <= CHK;
                    {s_ready, busy, done, err, core_rst_n} <= F_RUN;
`else
                    state                                  <= DONE;
                    {s_ready, busy, done, err, core_rst_n} <= F_DONE;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        if (s_data == xor_q) begin
                            state                                  <= DONE;
                            {s_ready, busy, done, err, core_rst_n} <= F_DONE;
                        end else begin
                            state                                  <= ERROR;
                            {s_ready, busy, done, err, core_rst_n} <= F_ERR;
                        end
                    end
                end
`endif
                DONE: begin
                    state <= DONE;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state                                  <= ERROR;
                    {s_ready, busy, done, err, core_rst_n} <= F_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (8-bit and 2-bit word address)
// driven with directed and random images, checked against a stream-level model.
module tb_imem_boot_loader;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst;
    // Instance A: ADDR_WIDTH = 8
    logic        va, ra, wea, crn_a, busy_a, done_a, err_a;
    logic [7:0]  da, addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  wl_a;
    // Instance B: ADDR_WIDTH = 2
    logic        vb, rb, web, crn_b, busy_b, done_b, err_b;
    logic [7:0]  db;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  wl_b;

    logic [39:0] wq0[$];
    logic [39:0] wq1[$];

    imem_boot_loader #(.ADDR_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .s_valid(va), .s_data(da), .s_ready(ra),
        .imem_we(wea), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .core_rst_n(crn_a), .busy(busy_a), .done(done_a), .err(err_a),
        .words_loaded(wl_a)
    );

    imem_boot_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .s_valid(vb), .s_data(db), .s_ready(rb),
        .imem_we(web), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .core_rst_n(crn_b), .busy(busy_b), .done(done_b), .err(err_b),
        .words_loaded(wl_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every write strobe and watch the core-reset/busy invariant
    always @(negedge clk) begin
        if (wea) wq0.push_back({addr_a, wdata_a});
        if (web) wq1.push_back({6'd0, addr_b, wdata_b});
        check_eq("crn_while_busy_a", 64'(crn_a & busy_a), 64'd0);
        check_eq("crn_while_busy_b", 64'(crn_b & busy_b), 64'd0);
    end

    function automatic logic [21:0] status(input bit sel);
        if (sel) return {16'(wl_b), rb, web, busy_b, done_b, err_b, crn_b};
        return {16'(wl_a), ra, wea, busy_a, done_a, err_a, crn_a};
    endfunction

    task automatic expect_status(input string tag, input bit sel, input bit r, input bit we,
                                 input bit b, input bit d, input bit e, input bit c, input int wl);
        check_eq(tag, 64'(status(sel)), 64'({16'(wl), r, we, b, d, e, c}));
    endtask

    task automatic drive(input bit sel, input bit v, input logic [7:0] d);
        if (sel) begin vb = v; db = d; end
        else begin va = v; da = d; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        va = 1'b0;
        vb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        expect_status("reset_a", 1'b0, 1, 0, 1, 0, 0, 0, 0);
        expect_status("reset_b", 1'b1, 1, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        wq0.delete();
        wq1.delete();
    endtask

    // gap: 0 back-to-back, 1 one idle cycle per byte, 2 random idle cycles
    task automatic send_stream(input bit sel, input bq_t s, input int gap);
        for (int i = 0; i < s.size(); i++) begin
            int idle;
            int n;
            bit h;
            idle = (gap == 0) ? 0 : (gap == 1) ? 1 : int'($urandom_range(0, 2));
            for (int k = 0; k < idle; k++) begin
                drive(sel, 1'b0, 8'($urandom));
                @(negedge clk);
                #1;
            end
            drive(sel, 1'b1, s[i]);
            n = 0;
            forever begin
                h = sel ? rb : ra;
                @(posedge clk);
                if (h) break;
                @(negedge clk);
                #1;
                n++;
                if (n > 50) begin
                    check_eq("handshake_timeout", 64'd0, 64'd1);
                    drive(sel, 1'b0, 8'd0);
                    return;
                end
            end
            @(negedge clk);
            #1;
        end
        drive(sel, 1'b0, 8'($urandom));
    endtask

    // Header, n random words when n fits, and (with checksum) a good or bad trailer
    task automatic make_stream(input int n, input int cap, input bit good, output bq_t s);
        logic [7:0] x;
        s.delete();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        x = 8'd0;
        if (n <= cap) begin
            for (int k = 0; k < 4 * n; k++) begin
                s.push_back(8'($urandom));
                x = x ^ s[s.size() - 1];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            s.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
`endif
        end
        if (good) x = 8'd0;
    endtask

    // Expected outcome of a whole stream, derived from its bytes alone
    task automatic check_load(input bit sel, input bq_t s);
        int          n;
        int          cap;
        logic [39:0] q[$];
        int unsigned w;
        bit          good;
        logic [7:0]  x;
        n   = int'(s[0]) + 256 * int'(s[1]);
        cap = sel ? 4 : 256;
        if (n > cap) begin
            expect_status("oversize", sel, 0, 0, 0, 0, 1, 0, 0);
            q = sel ? wq1 : wq0;
            check_eq("oversize_writes", 64'(q.size()), 64'd0);
            return;
        end
        good = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'd0;
        for (int k = 2; k < s.size() - 1; k++) x = x ^ s[k];
        good = (s[s.size() - 1] == x);
        expect_status("end_chk", sel, 0, 0, 0, good, !good, good, n);
`else
        x = 8'd0;
        expect_status("flush_cycle", sel, 0, n > 0, 1, 0, 0, 0, n);
        @(negedge clk);
        #1;
        expect_status("done_state", sel, 0, 0, 0, 1, 0, 1, n);
`endif
        if (sel) q = wq1;
        else q = wq0;
        check_eq("write_count", 64'(q.size()), 64'(n));
        for (int i = 0; i < q.size() && i < n; i++) begin
            int b;
            b = 2 + 4 * i;
            w = 32'(s[b]) + 32'(s[b + 1]) * 256 + 32'(s[b + 2]) * 65536 + 32'(s[b + 3]) * 16777216;
            check_eq("write_addr", 64'(q[i][39:32]), 64'(i));
            check_eq("write_data", 64'(q[i][31:0]), 64'(w));
        end
        if (x != 8'd0) check_eq("model_xor_unused", 64'(x), 64'(x));
    endtask

    initial begin
        bq_t t1;
        bq_t s;
        logic [7:0] x;
        rst = 1'b0;
        va  = 1'b0;
        vb  = 1'b0;
        da  = 8'd0;
        db  = 8'd0;

        t1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h70, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'd0;
        for (int k = 2; k < t1.size(); k++) x = x ^ t1[k];
        t1.push_back(x);
`endif

        // T1 basic two-word image
        do_reset();
        send_stream(1'b0, t1, 0);
        check_load(1'b0, t1);
        check_eq("t1_word0", 64'(wq0.size() > 0 ? wq0[0] : 40'd0), 64'h00_00500013);

        // T2 empty image
        do_reset();
        make_stream(0, 256, 1'b1, s);
        send_stream(1'b0, s, 0);
        check_load(1'b0, s);

        // T3 oversize header then full-capacity image on the small instance
        do_reset();
        make_stream(5, 4, 1'b1, s);
        send_stream(1'b1, s, 0);
        check_load(1'b1, s);
        repeat (3) @(negedge clk);
        #1;
        expect_status("error_sticky", 1'b1, 0, 0, 0, 0, 1, 0, 0);
        do_reset();
        make_stream(4, 4, 1'b1, s);
        send_stream(1'b1, s, 0);
        check_load(1'b1, s);

        // T4 valid toggling with junk data in idle cycles
        do_reset();
        send_stream(1'b0, t1, 1);
        check_load(1'b0, t1);

        // T5 reset in the middle of a load, then a clean reload
        do_reset();
        s = t1[0:7];
        send_stream(1'b0, s, 0);
        expect_status("mid_load", 1'b0, 1, 0, 1, 0, 0, 0, 1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        expect_status("mid_reset", 1'b0, 1, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        wq0.delete();
        send_stream(1'b0, t1, 0);
        check_load(1'b0, t1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // T6 wrong checksum keeps the core in reset
        do_reset();
        s = t1;
        s[s.size() - 1] = s[s.size() - 1] ^ 8'hFF;
        send_stream(1'b0, s, 0);
        check_load(1'b0, s);
`endif

        // Full 256-word image on the wide instance
        do_reset();
        make_stream(256, 256, 1'b1, s);
        send_stream(1'b0, s, 0);
        check_load(1'b0, s);

        // Random images on both instances
        for (int it = 0; it < 16; it++) begin
            bit sel;
            int n;
            sel = 1'($urandom_range(0, 1));
            n   = sel ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 8));
            if ($urandom_range(0, 5) == 0) n = int'($urandom_range(257, 65535));
            do_reset();
            make_stream(n, sel ? 4 : 256, 1'($urandom_range(0, 1)), s);
            send_stream(sel, s, 2);
            check_load(sel, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
